// File: rtl/lsu_axi_master.sv
// lsu_axi_master: turns single LSU load/store requests into AXI-lite
// read (AR/R) or write (AW/W/B) transactions, one at a time.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          LSU request handshake (ready only when idle)
//   req_wen, req_addr, req_wdata, req_wmask, req_size, req_unsigned
//                                request payload (store when req_wen=1)
//   resp_rdata, resp_err         load result and error flag of the last access
//   mem_finish                   one-cycle completion pulse (arbiter release)
//   araddr/arvalid/arready       AXI-lite read address channel
//   rdata/rresp/rvalid/rready    AXI-lite read data channel
//   awaddr/awvalid/awready       AXI-lite write address channel
//   wdata/wstrb/wvalid/wready    AXI-lite write data channel
//   bresp/bvalid/bready          AXI-lite write response channel
//
// Build option: define LSU_LOAD_EXT_EN to align load data by the low address
// bits and sign/zero-extend it by req_size/req_unsigned. Without it the raw
// 64-bit rdata is returned.
module lsu_axi_master #(
  parameter logic [1:0] RESP_OKAY = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_finish,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, AR, R, AWW, B} state_t;

  state_t state;

  // A write channel is finished once its valid has dropped or it handshakes now
  logic aw_done_c, w_done_c;
  assign aw_done_c = !awvalid || awready;
  assign w_done_c  = !wvalid  || wready;

  logic [63:0] load_data_c;

`ifdef LSU_LOAD_EXT_EN
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [63:0] shifted_c;

  // Bring the addressed bytes down to bit 0, then extend from the access size
  assign shifted_c = rdata >> {araddr[2:0], 3'b000};

  always_comb begin
    load_data_c = shifted_c;
    case (size_q)
      2'd0: load_data_c = unsigned_q ? {56'd0, shifted_c[7:0]}
                                     : {{56{shifted_c[7]}}, shifted_c[7:0]};
      2'd1: load_data_c = unsigned_q ? {48'd0, shifted_c[15:0]}
                                     : {{48{shifted_c[15]}}, shifted_c[15:0]};
      2'd2: load_data_c = unsigned_q ? {32'd0, shifted_c[31:0]}
                                     : {{32{shifted_c[31]}}, shifted_c[31:0]};
      default: load_data_c = shifted_c;
    endcase
  end
`else
  logic unused_cfg;
  assign load_data_c = rdata;
  assign unused_cfg  = ^{req_size, req_unsigned};
`endif

  // Transaction state machine; every output is a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
      mem_finish <= 1'b0;
      araddr     <= 32'd0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= 32'd0;
      awvalid    <= 1'b0;
      wdata      <= 64'd0;
      wstrb      <= 8'd0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
`ifdef LSU_LOAD_EXT_EN
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
`endif
    end else begin
      mem_finish <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            araddr    <= req_addr;
            awaddr    <= req_addr;
            wdata     <= req_wdata;
            wstrb     <= req_wmask;
`ifdef LSU_LOAD_EXT_EN
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
`endif
            if (req_wen) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= AWW;
            end else begin
              arvalid <= 1'b1;
              state   <= AR;
            end
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            rready     <= 1'b0;
            resp_rdata <= load_data_c;
            resp_err   <= (rresp != RESP_OKAY);
            mem_finish <= 1'b1;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        AWW: begin
          // AW and W retire independently; move on once both are done
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_done_c && w_done_c) begin
            bready <= 1'b1;
            state  <= B;
          end
        end
        B: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_err   <= (bresp != RESP_OKAY);
            mem_finish <= 1'b1;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
